// File: rtl/mem_bus_pkg.sv
// Shared types and default address map for the CPU data-side memory bus.
package mem_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // Default map: data memory in the low quarter, one LED register.
    localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK = 32'hC000_0000;
    localparam logic [31:0] LED_BASE  = 32'h4000_0010;
    localparam logic [31:0] LED_MASK  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } bus_state_e;

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Combinational base/mask window matcher; the lowest-index matching window wins.
module mem_bus_addr_decode #(
    parameter int                         N_SLAVES   = 4,
    parameter int                         ADDR_W     = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
    localparam int                        IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0]   addr_i,
    output logic                hit_o,
    output logic [N_SLAVES-1:0] onehot_o,
    output logic [IDX_W-1:0]    idx_o
);

    // Scan from the top so a lower-index match overwrites any higher one.
    always_comb begin
        hit_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_o       = 1'b1;
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// Registered CPU-to-slave bus decoder with wait-state handshake, timeout and
// error response for unmapped or malformed accesses.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int                         N_SLAVES   = 4,
    parameter int                         ADDR_W     = BUS_ADDR_W,
    parameter int                         DATA_W     = BUS_DATA_W,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
    parameter int                         TIMEOUT    = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    input  logic                       req_wr_i,
    input  logic                       req_rd_i,
    output logic                       req_stall_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_valid_o,
    output logic                       bus_err_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    output logic [N_SLAVES-1:0]        s_wr_o,
    output logic [N_SLAVES-1:0]        s_rd_o,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
    input  logic [N_SLAVES-1:0]        s_ready_i
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    bus_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [N_SLAVES-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                dec_hit;
    logic [N_SLAVES-1:0] dec_onehot;
    logic [IDX_W-1:0]    dec_idx;
    logic                req_any;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    mem_bus_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr_i   (req_addr_i),
        .hit_o    (dec_hit),
        .onehot_o (dec_onehot),
        .idx_o    (dec_idx)
    );

    assign req_any   = req_rd_i | req_wr_i;
    assign sel_ready = |(s_ready_i & onehot_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            onehot_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    wr_d     = req_wr_i;
                    onehot_d = dec_onehot;
                    idx_d    = dec_idx;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    state_d  = (dec_hit && (req_rd_i ^ req_wr_i)) ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d = wr_q ? '0 : sel_rdata;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes exist only in ACCESS, so reset or timeout drops them at once.
    assign s_wr_o      = (state_q == ACCESS &&  wr_q) ? onehot_q : '0;
    assign s_rd_o      = (state_q == ACCESS && !wr_q) ? onehot_q : '0;
    assign s_addr_o    = addr_q;
    assign s_wdata_o   = wdata_q;
    assign rsp_valid_o = (state_q == RESP);
    assign bus_err_o   = (state_q == ERR);
    assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    assign req_stall_o = ((state_q == IDLE) && req_any) || (state_q == ACCESS);

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed self-checking bench for mem_bus_decoder with a four-slave map.
module tb_mem_bus_decoder;
    import mem_bus_pkg::*;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    // Slave 2 overlaps the LED window to exercise lowest-index priority.
    localparam logic [N*32-1:0] BASES = {32'hC000_0000, 32'h4000_0000, LED_BASE, DMEM_BASE};
    localparam logic [N*32-1:0] MASKS = {32'hF000_0000, 32'hFFFF_FF00, LED_MASK, DMEM_MASK};

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_wr;
    logic          req_rd;
    logic          req_stall;
    logic [31:0]   rsp_rdata;
    logic          rsp_valid;
    logic          bus_err;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [N-1:0]  s_wr;
    logic [N-1:0]  s_rd;
    logic [N*32-1:0] s_rdata;
    logic [N-1:0]  s_ready;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_bus_decoder #(
        .N_SLAVES   (N),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLAVE_BASE (BASES),
        .SLAVE_MASK (MASKS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wr_i    (req_wr),
        .req_rd_i    (req_rd),
        .req_stall_o (req_stall),
        .rsp_rdata_o (rsp_rdata),
        .rsp_valid_o (rsp_valid),
        .bus_err_o   (bus_err),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_wr_o      (s_wr),
        .s_rd_o      (s_rd),
        .s_rdata_i   (s_rdata),
        .s_ready_i   (s_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // slave < 0 means an error response is expected in cycle 1; waits >= TIMEOUT
    // means the selected slave never answers.
    task automatic runTransfer(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int slave, input int waits, input logic [31:0] expRdata);
        int lastAccess;
        int endCycle;
        bit isErr;
        bit inAccess;
        logic [N-1:0] sel;
        sel = (slave >= 0) ? N'(1 << slave) : '0;
        if (slave < 0) begin
            lastAccess = 0;
            isErr      = 1'b1;
        end else if (waits >= TIMEOUT) begin
            lastAccess = TIMEOUT;
            isErr      = 1'b1;
        end else begin
            lastAccess = waits + 1;
            isErr      = 1'b0;
        end
        endCycle = lastAccess + 1;
        for (int k = 0; k <= endCycle + 1; k++) begin
            @(posedge clk);
            #1;
            if (k <= endCycle) applyStimulus(rd, wr, addr, wdata);
            else               applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            s_ready = ~sel | ((k == waits + 1) ? sel : '0);
            @(negedge clk);
            inAccess = (slave >= 0) && (k >= 1) && (k <= lastAccess);
            checkOutput($sformatf("%s.c%0d.stall", tag, k), 32'(req_stall), 32'((k == 0) || inAccess));
            checkOutput($sformatf("%s.c%0d.s_rd", tag, k), 32'(s_rd), 32'((inAccess && !wr) ? sel : '0));
            checkOutput($sformatf("%s.c%0d.s_wr", tag, k), 32'(s_wr), 32'((inAccess && wr) ? sel : '0));
            checkOutput($sformatf("%s.c%0d.valid", tag, k), 32'(rsp_valid), 32'((k == endCycle) && !isErr));
            checkOutput($sformatf("%s.c%0d.err", tag, k), 32'(bus_err), 32'((k == endCycle) && isErr));
            if (k == endCycle) begin
                checkOutput($sformatf("%s.rdata", tag), rsp_rdata, isErr ? 32'h0 : expRdata);
            end
            if (inAccess) begin
                checkOutput($sformatf("%s.c%0d.s_addr", tag, k), s_addr, addr);
                checkOutput($sformatf("%s.c%0d.s_wdata", tag, k), s_wdata, wdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        s_ready = '0;
        s_rdata = {32'hDEAD_BEEF, 32'hCAFE_0002, 32'hAAAA_0001, 32'h1234_5678};
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.stall", 32'(req_stall), 32'h0);
        checkOutput("reset.valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset.err", 32'(bus_err), 32'h0);
        checkOutput("reset.rdata", rsp_rdata, 32'h0);
        checkOutput("reset.s_addr", s_addr, 32'h0);
        checkOutput("reset.s_wdata", s_wdata, 32'h0);
        checkOutput("reset.s_wr", 32'(s_wr), 32'h0);
        checkOutput("reset.s_rd", 32'(s_rd), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        runTransfer("rd_dmem", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h1234_5678);
        runTransfer("wr_led", 1'b0, 1'b1, 32'h4000_0010, 32'h0000_00FF, 1, 3, 32'h0);
        runTransfer("rd_overlap", 1'b1, 1'b0, 32'h4000_0020, 32'h0, 2, 1, 32'hCAFE_0002);
        runTransfer("rd_unmapped", 1'b1, 1'b0, 32'h8000_0000, 32'h0, -1, 0, 32'h0);
        runTransfer("timeout", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 100, 32'h0);
        runTransfer("rd_and_wr", 1'b1, 1'b1, 32'h0000_0040, 32'h5555_5555, -1, 0, 32'h0);

        // Reset while ACCESS is pending must drop the strobe with no response.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h0);
        s_ready = 4'b1110;
        @(negedge clk);
        checkOutput("rst_mid.c0.stall", 32'(req_stall), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst_mid.c1.s_rd", 32'(s_rd), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid.c2.s_rd", 32'(s_rd), 32'h0);
        checkOutput("rst_mid.c2.s_wr", 32'(s_wr), 32'h0);
        checkOutput("rst_mid.c2.s_addr", s_addr, 32'h0);
        checkOutput("rst_mid.c2.stall", 32'(req_stall), 32'h0);
        for (int k = 2; k <= 4; k++) begin
            if (k > 2) begin
                @(posedge clk);
                @(negedge clk);
            end
            checkOutput($sformatf("rst_mid.c%0d.valid", k), 32'(rsp_valid), 32'h0);
            checkOutput($sformatf("rst_mid.c%0d.err", k), 32'(bus_err), 32'h0);
        end
        runTransfer("post_rst", 1'b1, 1'b0, 32'hC000_0004, 32'h0, 3, 0, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
